writeback_stage: RTL and testbench

Final pipeline stage of the RV32I core; sole driver of the register file write port (write_enable, write_reg, write_data). It merges two producers, execute-unit results and load responses from the data-memory interface, into that single port, one write per cycle. Load data is sign/zero-extended and lane-aligned here. A small in-order buffer absorbs execute results that lose arbitration to a load.

---
 rtl/core_pkg.sv | 26 ++
 rtl/wb_result_fifo.sv | 65 ++++++
 rtl/writeback_stage.sv | 139 +++++++++++++
 tb/tb_writeback_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register/data widths, load funct3 encodings,
// writeback source selection and the buffered execute-result entry.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LOAD,
    WB_SRC_FIFO,
    WB_SRC_BYPASS
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous in-order FIFO holding execute results that lost the
// writeback port to a load. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
module wb_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // State registers; storage contents need no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage: merges load responses and execute results
// into the single register-file write port. Loads always win; execute
// results that lose are buffered and retire in acceptance order.
module writeback_stage
  import core_pkg::*;
#(
  parameter int unsigned EX_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_addr_lo,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  wb_write_enable,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [XLEN-1:0]       wb_write_data,
  output logic                  wb_pending
);

  localparam int unsigned CW = $clog2(EX_FIFO_DEPTH) + 1;

  // Lane-select and extend a raw memory word according to the load type
  function automatic logic [XLEN-1:0] format_load(
    input logic [2:0]      f3,
    input logic [1:0]      addr_lo,
    input logic [XLEN-1:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   format_load = {{24{b[7]}}, b};
      F3_LBU:  format_load = {24'b0, b};
      F3_LH:   format_load = {{16{h[15]}}, h};
      F3_LHU:  format_load = {16'b0, h};
      default: format_load = word;
    endcase
  endfunction

  wb_src_e         wb_src;
  wb_entry_t       push_entry, head_entry;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            fifo_push, fifo_pop;
  logic            ex_accept, ex_live, ld_live;

  logic                  wb_we_q,   wb_we_d;
  logic [REG_ADDR_W-1:0] wb_reg_q,  wb_reg_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  // Readiness depends only on registered occupancy and reset
  assign ex_ready  = reset_n & ~fifo_full;
  assign ex_accept = ex_valid & ex_ready;
  assign ex_live   = ex_accept & (ex_rd != '0);
  assign ld_live   = ld_valid & (ld_rd != '0);

  // Priority: load, then oldest buffered result, then same-cycle bypass
  always_comb begin
    wb_src = WB_SRC_NONE;
    if (ld_live) begin
      wb_src = WB_SRC_LOAD;
    end else if (!fifo_empty) begin
      wb_src = WB_SRC_FIFO;
    end else if (ex_live) begin
      wb_src = WB_SRC_BYPASS;
    end
  end

  assign fifo_push       = ex_live && (wb_src != WB_SRC_BYPASS);
  assign fifo_pop        = (wb_src == WB_SRC_FIFO);
  assign push_entry.rd   = ex_rd;
  assign push_entry.data = ex_data;

  wb_result_fifo #(
    .DEPTH (EX_FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next write-port values; reg/data hold when no write is issued
  always_comb begin
    wb_we_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    case (wb_src)
      WB_SRC_LOAD: begin
        wb_we_d   = 1'b1;
        wb_reg_d  = ld_rd;
        wb_data_d = format_load(ld_funct3, ld_addr_lo, ld_data);
      end
      WB_SRC_FIFO: begin
        wb_we_d   = 1'b1;
        wb_reg_d  = head_entry.rd;
        wb_data_d = head_entry.data;
      end
      WB_SRC_BYPASS: begin
        wb_we_d   = 1'b1;
        wb_reg_d  = ex_rd;
        wb_data_d = ex_data;
      end
      default: ;
    endcase
  end

  // Registered write port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_we_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_write_enable = wb_we_q;
  assign wb_write_reg    = wb_reg_q;
  assign wb_write_data   = wb_data_q;
  assign wb_pending      = (fifo_count != '0);

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed steps followed by a
// randomized phase, checked against a queue-based reference model.
module tb_writeback_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_data;
  logic        wb_write_enable;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        wb_pending;

  writeback_stage #(.EX_FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_rd           (ex_rd),
    .ex_data         (ex_data),
    .ld_valid        (ld_valid),
    .ld_rd           (ld_rd),
    .ld_funct3       (ld_funct3),
    .ld_addr_lo      (ld_addr_lo),
    .ld_data         (ld_data),
    .wb_write_enable (wb_write_enable),
    .wb_write_reg    (wb_write_reg),
    .wb_write_data   (wb_write_data),
    .wb_pending      (wb_pending)
  );

  always #5 clk = ~clk;

  // Reference model: pending execute results as {rd, data}, plus the
  // last value presented on the write port.
  logic [36:0] q[$];
  logic        m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * lo)) & 32'hFF;
        if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * lo[1])) & 32'hFFFF;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check ex_ready, advance model at
  // the rising edge, check write port #1 later, return to negedge.
  task automatic step(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                      input logic ldv, input logic [4:0] ldrd, input logic [2:0] f3,
                      input logic [1:0] lo, input logic [31:0] ldd, input logic rstn,
                      output logic accepted);
    logic        exp_ready;
    logic [36:0] e;
    reset_n    = rstn;
    ex_valid   = exv;
    ex_rd      = exrd;
    ex_data    = exd;
    ld_valid   = ldv;
    ld_rd      = ldrd;
    ld_funct3  = f3;
    ld_addr_lo = lo;
    ld_data    = ldd;
    #1;
    exp_ready = rstn && (q.size() < DEPTH);
    chk("ex_ready", {31'b0, ex_ready}, {31'b0, exp_ready});
    accepted = exv && exp_ready;
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      m_en   = 1'b0;
      m_reg  = '0;
      m_data = '0;
    end else begin
      if (accepted && exrd != 0) q.push_back({exrd, exd});
      if (ldv && ldrd != 0) begin
        m_en   = 1'b1;
        m_reg  = ldrd;
        m_data = ref_load(f3, lo, ldd);
      end else if (q.size() != 0) begin
        e      = q.pop_front();
        m_en   = 1'b1;
        m_reg  = e[36:32];
        m_data = e[31:0];
      end else begin
        m_en = 1'b0;
      end
    end
    #1;
    chk("wb_write_enable", {31'b0, wb_write_enable}, {31'b0, m_en});
    chk("wb_write_reg", {27'b0, wb_write_reg}, {27'b0, m_reg});
    chk("wb_write_data", wb_write_data, m_data);
    chk("wb_pending", {31'b0, wb_pending}, {31'b0, (q.size() != 0)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 3'b010, 0, 0, 1, a);
  endtask

  initial begin
    logic acc;
    int   idx;
    m_en = 1'b0; m_reg = '0; m_data = '0;
    @(negedge clk);

    // Reset held 3 cycles with an execute result offered
    for (int i = 0; i < 3; i++) step(1, 5'd9, 32'hDEAD, 0, 0, 3'b010, 0, 0, 0, acc);
    chk("reset_we", {31'b0, wb_write_enable}, 32'd0);
    chk("reset_data", wb_write_data, 32'd0);

    // Bypass with empty buffer and no load
    step(1, 5'd5, 32'h1234, 0, 0, 3'b010, 0, 0, 1, acc);
    chk("bypass_reg", {27'b0, wb_write_reg}, 32'd5);
    chk("bypass_data", wb_write_data, 32'h1234);
    chk("bypass_pending", {31'b0, wb_pending}, 32'd0);
    idle(1);

    // Collision: load wins, execute result follows next cycle
    step(1, 5'd7, 32'h11, 1, 5'd3, 3'b010, 0, 32'hAABBCCDD, 1, acc);
    chk("coll_ld_data", wb_write_data, 32'hAABBCCDD);
    chk("coll_pending", {31'b0, wb_pending}, 32'd1);
    idle(1);
    chk("coll_ex_reg", {27'b0, wb_write_reg}, 32'd7);
    chk("coll_ex_data", wb_write_data, 32'h11);

    // Load formatting
    step(0, 0, 0, 1, 5'd4, 3'b000, 2'd3, 32'h80FF7F01, 1, acc);
    chk("fmt_lb", wb_write_data, 32'hFFFFFF80);
    step(0, 0, 0, 1, 5'd4, 3'b100, 2'd1, 32'h80FF7F01, 1, acc);
    chk("fmt_lbu", wb_write_data, 32'h0000007F);
    step(0, 0, 0, 1, 5'd4, 3'b001, 2'd2, 32'h80FF7F01, 1, acc);
    chk("fmt_lh", wb_write_data, 32'hFFFF80FF);
    step(0, 0, 0, 1, 5'd4, 3'b101, 2'd0, 32'h80FF7F01, 1, acc);
    chk("fmt_lhu", wb_write_data, 32'h00007F01);
    step(0, 0, 0, 1, 5'd4, 3'b011, 2'd1, 32'h80FF7F01, 1, acc);
    chk("fmt_other", wb_write_data, 32'h80FF7F01);
    idle(1);

    // Backpressure: 4 load cycles while execute results 1,2,3 stream in
    idx = 1;
    for (int c = 0; c < 20 && idx <= 3; c++) begin
      step(1, 5'(idx), 32'h100 + idx, (c < 4), 5'(10 + c), 3'b010, 0, 32'h5000 + c, 1, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 32'd4);
    idle(3);

    // rd=0 from both sources is accepted and discarded
    step(1, 5'd0, 32'hBAD0, 0, 0, 3'b010, 0, 0, 1, acc);
    chk("rd0_ex_accepted", {31'b0, acc}, 32'd1);
    chk("rd0_ex_we", {31'b0, wb_write_enable}, 32'd0);
    step(0, 0, 0, 1, 5'd0, 3'b010, 0, 32'hBAD1, 1, acc);
    chk("rd0_ld_we", {31'b0, wb_write_enable}, 32'd0);
    chk("rd0_pending", {31'b0, wb_pending}, 32'd0);

    // Randomized traffic, with an occasional reset
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom), $urandom,
           $urandom_range(0, 9) < 4, 5'($urandom), 3'($urandom), 2'($urandom), $urandom,
           $urandom_range(0, 79) != 0, acc);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
